// File: rtl/serv_mtimer.sv
// RISC-V machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp and a
// registered level interrupt, on a 32-bit single-cycle-ack Wishbone slave.
module serv_mtimer #(
  parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_mtip
);

  // Bus handshake: a transfer commits on the edge where o_wb_ack rises
  // (i_wb_cyc high while ack is low); ack lasts one cycle and the master
  // drops i_wb_cyc in the ack cycle. Read data is registered on that edge.

  logic [63:0] mtime;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp;
  logic [31:0] hi_shadow;
  logic [15:0] prescale;
  logic [15:0] pcnt;
  logic [15:0] pcnt_next;
  logic        tick;
  logic        commit;
  logic        wr;
  logic        rd;
  logic [31:0] rdata;
  logic [31:0] ps_merged;

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  assign commit = i_wb_cyc & ~o_wb_ack;
  assign wr     = commit & i_wb_we;
  assign rd     = commit & ~i_wb_we;
  assign tick   = (pcnt == prescale);

  assign ps_merged = merge({16'd0, prescale}, i_wb_dat, i_wb_sel);

  // A bus write to either mtime half replaces that cycle's increment.
  always_comb begin
    mtime_next = mtime;
    if (wr && i_wb_adr == 3'd0) begin
      mtime_next = {mtime[63:32], merge(mtime[31:0], i_wb_dat, i_wb_sel)};
    end else if (wr && i_wb_adr == 3'd1) begin
      mtime_next = {merge(mtime[63:32], i_wb_dat, i_wb_sel), mtime[31:0]};
    end else if (tick) begin
      mtime_next = mtime + 64'd1;
    end
  end

  always_comb begin
    pcnt_next = pcnt + 16'd1;
    if (wr && i_wb_adr == 3'd4) begin
      pcnt_next = 16'd0;
    end else if (tick) begin
      pcnt_next = 16'd0;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (i_wb_adr)
      3'd0:    rdata = mtime[31:0];
      3'd1:    rdata = hi_shadow;
      3'd2:    rdata = mtimecmp[31:0];
      3'd3:    rdata = mtimecmp[63:32];
      3'd4:    rdata = {16'd0, prescale};
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mtime     <= 64'd0;
      mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      hi_shadow <= 32'd0;
      prescale  <= PRESCALE_RESET;
      pcnt      <= 16'd0;
      o_wb_ack  <= 1'b0;
      o_wb_rdt  <= 32'd0;
      o_mtip    <= 1'b0;
    end else begin
      mtime    <= mtime_next;
      pcnt     <= pcnt_next;
      o_wb_ack <= commit;
      o_mtip   <= (mtime >= mtimecmp);
      if (rd) begin
        o_wb_rdt <= rdata;
      end
      // Low-word read freezes the high word so a 32-bit master sees a coherent pair.
      if (wr && i_wb_adr == 3'd1) begin
        hi_shadow <= merge(mtime[63:32], i_wb_dat, i_wb_sel);
      end else if (rd && i_wb_adr == 3'd0) begin
        hi_shadow <= mtime[63:32];
      end
      if (wr && i_wb_adr == 3'd2) begin
        mtimecmp[31:0] <= merge(mtimecmp[31:0], i_wb_dat, i_wb_sel);
      end
      if (wr && i_wb_adr == 3'd3) begin
        mtimecmp[63:32] <= merge(mtimecmp[63:32], i_wb_dat, i_wb_sel);
      end
      if (wr && i_wb_adr == 3'd4) begin
        prescale <= ps_merged[15:0];
      end
    end
  end

endmodule
